// File: rtl/perceptron_introduction.sv
// Single-layer perceptron in Q16.16 with on-chip perceptron-rule training and live inference.
// Optional macro PERCEPTRON_SAT_EN: saturating sfp arithmetic instead of two's-complement wrap.
module perceptron_introduction #(
  parameter int size = 2,
  parameter int num  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [size-1:0][31:0]          values,
  input  logic [1:0]                     activation,
  output logic [31:0]                    prediction,
  input  logic                           training,
  input  logic signed [31:0]             epochs,
  input  logic [31:0]                    learning_rate,
  input  logic [num-1:0][size-1:0][31:0] train_values,
  input  logic [num-1:0][31:0]           expected,
  output logic                           done_training
);

  localparam int IW = (num > 1) ? $clog2(num) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(num - 1);
  localparam logic signed [31:0] SFP_ONE = 32'sh0001_0000;
  localparam logic signed [31:0] SFP_NEG_ONE = 32'shFFFF_0000;
  localparam logic signed [31:0] SFP_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SFP_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic signed [31:0] sfp_add_f(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
`ifdef PERCEPTRON_SAT_EN
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? SFP_MIN : SFP_MAX;
    else return s[31:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic signed [31:0] sfp_sub_f(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
`ifdef PERCEPTRON_SAT_EN
    logic signed [32:0] s;
    s = {a[31], a} - {b[31], b};
    if (s[32] != s[31]) return s[32] ? SFP_MIN : SFP_MAX;
    else return s[31:0];
`else
    return a - b;
`endif
  endfunction

  function automatic logic signed [31:0] sfp_mul_f(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
`ifdef PERCEPTRON_SAT_EN
    p = p >>> 16;
    if (p > 64'sh0000_0000_7FFF_FFFF) return SFP_MAX;
    else if (p < 64'shFFFF_FFFF_8000_0000) return SFP_MIN;
    else return p[31:0];
`else
    return 32'(p >>> 16);
`endif
  endfunction

  function automatic logic signed [31:0] dot_f(input logic [size-1:0][31:0] w,
                                               input logic [size-1:0][31:0] x,
                                               input logic signed [31:0]    b);
    logic signed [31:0] acc;
    acc = b;
    for (int j = 0; j < size; j++) begin
      acc = sfp_add_f(acc, sfp_mul_f(w[j], x[j]));
    end
    return acc;
  endfunction

  // Unknown activation codes fall back to the Heaviside step.
  function automatic logic [31:0] act_f(input logic signed [31:0] s, input logic [1:0] a);
    logic [31:0] r;
    case (a)
      2'd1:    r = (s > 32'sd0) ? SFP_ONE : SFP_NEG_ONE;
      2'd2:    r = s;
      default: r = (s > 32'sd0) ? SFP_ONE : 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_t                  state_r, state_s;
  logic [size-1:0][31:0]   w_r, w_s;
  logic signed [31:0]      bias_r, bias_s;
  logic [IW-1:0]           i_r, i_s;
  logic signed [31:0]      e_r, e_s;
  logic signed [31:0]      epochs_r, epochs_s;
  logic [31:0]             prediction_r, pred_s;
  logic                    done_r;

  logic [size-1:0][31:0]   train_x_s;
  logic signed [31:0]      train_sum_s;
  logic [31:0]             train_pred_s;
  logic signed [31:0]      err_s;
  logic signed [31:0]      lr_err_s;
  logic [31:0]             infer_pred_s;

  // Next-state, weight update and inference datapath.
  always_comb begin
    state_s      = state_r;
    w_s          = w_r;
    bias_s       = bias_r;
    i_s          = i_r;
    e_s          = e_r;
    epochs_s     = epochs_r;
    pred_s       = prediction_r;
    train_x_s    = train_values[i_r];
    train_sum_s  = dot_f(w_r, train_x_s, bias_r);
    train_pred_s = act_f(train_sum_s, activation);
    err_s        = sfp_sub_f(expected[i_r], train_pred_s);
    lr_err_s     = sfp_mul_f(learning_rate, err_s);
    infer_pred_s = act_f(dot_f(w_r, values, bias_r), activation);

    case (state_r)
      ST_IDLE: begin
        pred_s = infer_pred_s;
        if (training) begin
          w_s      = '0;
          bias_s   = 32'sd0;
          i_s      = '0;
          e_s      = 32'sd0;
          epochs_s = epochs;
          if (epochs <= 32'sd0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_TRAIN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_TRAIN: begin
        // Error is scaled by lr first, then by each input.
        for (int j = 0; j < size; j++) begin
          w_s[j] = sfp_add_f(w_r[j], sfp_mul_f(lr_err_s, train_x_s[j]));
        end
        bias_s = sfp_add_f(bias_r, lr_err_s);
        if (i_r == I_LAST) begin
          i_s = '0;
          if (e_r >= epochs_r - 32'sd1) begin
            state_s = ST_DONE;
          end else begin
            e_s = e_r + 32'sd1;
          end
        end else begin
          i_s = i_r + IW'(1);
        end
      end
      ST_DONE: begin
        pred_s = infer_pred_s;
        if (training) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, weights and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      w_r          <= '0;
      bias_r       <= 32'sd0;
      i_r          <= '0;
      e_r          <= 32'sd0;
      epochs_r     <= 32'sd0;
      prediction_r <= 32'h0000_0000;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      w_r          <= w_s;
      bias_r       <= bias_s;
      i_r          <= i_s;
      e_r          <= e_s;
      epochs_r     <= epochs_s;
      prediction_r <= pred_s;
      done_r       <= (state_s == ST_DONE);
    end
  end

  assign prediction    = prediction_r;
  assign done_training = done_r;

endmodule

// File: tb/tb_perceptron_introduction.sv
// Directed bench for perceptron_introduction: gate learning, latency, activations, reset and retrain.
module tb_perceptron_introduction;

  localparam logic [31:0] ONE   = 32'h0001_0000;
  localparam logic [31:0] ZERO  = 32'h0000_0000;
  localparam logic [31:0] M_ONE = 32'hFFFF_0000;
  localparam logic [31:0] M_TWO = 32'hFFFE_0000;
  localparam logic [31:0] TWO   = 32'h0002_0000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0][31:0]     values;
  logic [1:0]           activation;
  logic [31:0]          prediction;
  logic                 training;
  logic signed [31:0]   epochs;
  logic [31:0]          learning_rate;
  logic [3:0][1:0][31:0] train_values;
  logic [3:0][31:0]     expected;
  logic                 done_training;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  perceptron_introduction #(.size(2), .num(4)) dut (
    .clk(clk), .rst_n(rst_n), .values(values), .activation(activation),
    .prediction(prediction), .training(training), .epochs(epochs),
    .learning_rate(learning_rate), .train_values(train_values),
    .expected(expected), .done_training(done_training)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples in order (x1,x0) = (1,1),(1,0),(0,1),(0,0); tt[k] is the target for k = {x1,x0}.
  task automatic load_set(input logic [3:0] tt);
    for (int s = 0; s < 4; s++) begin
      logic [1:0] k;
      k = 2'(3 - s);
      train_values[s][0] = k[0] ? ONE : ZERO;
      train_values[s][1] = k[1] ? ONE : ZERO;
      expected[s]        = tt[k] ? ONE : ZERO;
    end
  endtask

  // Scoreboarded inference: expectation queued on drive, popped one cycle later.
  task automatic apply(input string tag, input logic [31:0] x0, input logic [31:0] x1,
                       input logic [31:0] exp);
    values[0] = x0;
    values[1] = x1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    check(tag_q.pop_front(), prediction, exp_q.pop_front());
  endtask

  task automatic gate_check(input string name, input logic [3:0] tt);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] kk;
      kk = 2'(k);
      apply($sformatf("%s_inf%0d", name, k), kk[0] ? ONE : ZERO, kk[1] ? ONE : ZERO,
            tt[kk] ? ONE : ZERO);
    end
  endtask

  task automatic run_train(input string tag, input logic signed [31:0] ep, input int exp_cycles);
    int cyc;
    cyc = 0;
    epochs   = ep;
    training = 1'b1;
    do begin
      tick();
      cyc++;
    end while (!done_training && cyc < 200);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cycles));
  endtask

  task automatic stop_train();
    training = 1'b0;
    tick();
  endtask

  task automatic check_weights(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] b);
    check({tag, "_w0"}, dut.w_r[0], w0);
    check({tag, "_w1"}, dut.w_r[1], w1);
    check({tag, "_bias"}, dut.bias_r, b);
  endtask

  initial begin
    int mis;
    rst_n         = 1'b0;
    training      = 1'b0;
    epochs        = 32'sd0;
    activation    = 2'd0;
    learning_rate = ONE;
    values        = '0;
    load_set(4'b1000);
    tick();
    tick();
    check("rst_pred", prediction, ZERO);
    check("rst_done", {31'd0, done_training}, 32'd0);
    check_weights("rst", ZERO, ZERO, ZERO);
    rst_n = 1'b1;
    tick();

    // AND, 5 epochs: one start cycle plus 20 training cycles.
    run_train("and", 32'sd5, 21);
    check_weights("and", TWO, ONE, M_TWO);
    gate_check("and", 4'b1000);
    check("and_done_held", {31'd0, done_training}, 32'd1);

    // Other activations on the frozen AND weights.
    activation = 2'd2;
    apply("ident_00", ZERO, ZERO, M_TWO);
    apply("ident_11", ONE, ONE, ONE);
    activation = 2'd1;
    apply("sign_00", ZERO, ZERO, M_ONE);
    apply("sign_11", ONE, ONE, ONE);
    activation = 2'd3;
    apply("rsvd_00", ZERO, ZERO, ZERO);
    apply("rsvd_11", ONE, ONE, ONE);
    activation = 2'd0;

    // Drop and re-raise: full retrain reproduces the same weights.
    stop_train();
    check("drop_done", {31'd0, done_training}, 32'd0);
    run_train("and_re", 32'sd5, 21);
    check_weights("and_re", TWO, ONE, M_TWO);
    stop_train();

    load_set(4'b1110);
    run_train("or", 32'sd10, 41);
    gate_check("or", 4'b1110);
    stop_train();

    load_set(4'b0111);
    run_train("nand", 32'sd10, 41);
    gate_check("nand", 4'b0111);
    stop_train();

    // XOR is not linearly separable; at least one pattern must come out wrong.
    load_set(4'b0110);
    run_train("xor", 32'sd5, 21);
    mis = 0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] kk;
      kk = 2'(k);
      values[0] = kk[0] ? ONE : ZERO;
      values[1] = kk[1] ? ONE : ZERO;
      tick();
      if (prediction !== ((kk[0] ^ kk[1]) ? ONE : ZERO)) mis++;
    end
    check("xor_mispredict", {31'd0, (mis > 0)}, 32'd1);
    stop_train();

    // Zero epochs: straight to DONE with cleared weights.
    run_train("ep0", 32'sd0, 1);
    check_weights("ep0", ZERO, ZERO, ZERO);
    apply("ep0_inf11", ONE, ONE, ZERO);
    apply("ep0_inf00", ZERO, ZERO, ZERO);
    stop_train();

    // Reset in the middle of training, then a clean restart.
    load_set(4'b1000);
    values[0] = ONE;
    values[1] = ONE;
    epochs    = 32'sd5;
    training  = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_done", {31'd0, done_training}, 32'd0);
    check("mid_rst_pred", prediction, ZERO);
    check_weights("mid_rst", ZERO, ZERO, ZERO);
    rst_n = 1'b1;
    run_train("after_rst", 32'sd5, 21);
    check_weights("after_rst", TWO, ONE, M_TWO);
    gate_check("after_rst", 4'b1000);
    stop_train();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
